aoi_4: RTL and testbench



---
 rtl/aoi_pkg.sv | 19 +
 rtl/aoi_4_core.sv | 32 +++
 rtl/aoi_4.sv | 103 ++++++++++
 tb/tb_aoi_4.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/aoi_pkg.sv
// aoi_pkg
// Shared constants for the clocked AND-OR-INVERT gate aoi_4 and its
// combinational core aoi_4_core.
package aoi_pkg;

    // Product terms: three 2-input ANDs plus one 3-input AND.
    localparam int AOI_4_NUM_TERMS = 4;

    // Number of data inputs A..I.
    localparam int AOI_4_NUM_INPUTS = 9;

    // Depth of the optional input synchronizer.
    localparam int AOI_4_SYNC_STAGES = 2;

    // Y reset value. It equals the all-inputs-zero result, so leaving reset
    // with idle inputs does not glitch the output.
    localparam logic AOI_4_Y_RST = 1'b1;

endpackage

// File: rtl/aoi_4_core.sv
// aoi_4_core
// Combinational 2-2-2-3 AND-OR-INVERT core.
// Ports:
//   A..I   in   data inputs (A,B term 0; C,D term 1; E,F term 2; G,H,I term 3)
//   terms  out  product terms, bit k = AND term k
//   y      out  ~(OR of all terms)
module aoi_4_core
    import aoi_pkg::*;
(
    input  logic                       A,
    input  logic                       B,
    input  logic                       C,
    input  logic                       D,
    input  logic                       E,
    input  logic                       F,
    input  logic                       G,
    input  logic                       H,
    input  logic                       I,
    output logic [AOI_4_NUM_TERMS-1:0] terms,
    output logic                       y
);

    always_comb begin
        terms    = '0;
        terms[0] = A & B;
        terms[1] = C & D;
        terms[2] = E & F;
        terms[3] = G & H & I;
        y        = ~(|terms);
    end

endmodule

// File: rtl/aoi_4.sv
// aoi_4
// Clocked 4-wide AND-OR-INVERT gate (SN74H54-style 2-2-2-3 inputs) with a
// registered active-low result and registered product-term status.
// Optional build macro AOI_4_INPUT_SYNC_EN: routes all nine inputs through a
// two-flop synchronizer before the core (latency 3 instead of 1). The port
// list is identical in both builds.
// Ports:
//   CLK    in   rising-edge clock
//   RST_N  in   synchronous active-low reset
//   A..I   in   data inputs
//   Y      out  registered ~(A&B | C&D | E&F | G&H&I)
//   TERMS  out  registered {G&H&I, E&F, C&D, A&B}
module aoi_4
    import aoi_pkg::*;
(
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       A,
    input  logic                       B,
    input  logic                       C,
    input  logic                       D,
    input  logic                       E,
    input  logic                       F,
    input  logic                       G,
    input  logic                       H,
    input  logic                       I,
    output logic                       Y,
    output logic [AOI_4_NUM_TERMS-1:0] TERMS
);

    logic [AOI_4_NUM_INPUTS-1:0] in_vec;
    logic [AOI_4_NUM_INPUTS-1:0] core_in;
    logic [AOI_4_NUM_TERMS-1:0]  core_terms;
    logic                        core_y;

    logic                        y_d;
    logic                        y_q;
    logic [AOI_4_NUM_TERMS-1:0]  terms_d;
    logic [AOI_4_NUM_TERMS-1:0]  terms_q;

    assign in_vec = {A, B, C, D, E, F, G, H, I};

`ifdef AOI_4_INPUT_SYNC_EN
    logic [AOI_4_NUM_INPUTS-1:0] sync_d [AOI_4_SYNC_STAGES];
    logic [AOI_4_NUM_INPUTS-1:0] sync_q [AOI_4_SYNC_STAGES];

    always_comb begin
        sync_d[0] = in_vec;
        for (int s = 1; s < AOI_4_SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int s = 0; s < AOI_4_SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    assign core_in = sync_q[AOI_4_SYNC_STAGES-1];
`else
    assign core_in = in_vec;
`endif

    aoi_4_core u_core (
        .A     (core_in[8]),
        .B     (core_in[7]),
        .C     (core_in[6]),
        .D     (core_in[5]),
        .E     (core_in[4]),
        .F     (core_in[3]),
        .G     (core_in[2]),
        .H     (core_in[1]),
        .I     (core_in[0]),
        .terms (core_terms),
        .y     (core_y)
    );

    // Y and TERMS load together from the same core evaluation, which keeps
    // Y == ~|TERMS in every cycle, reset included.
    always_comb begin
        y_d     = core_y;
        terms_d = core_terms;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            y_q     <= AOI_4_Y_RST;
            terms_q <= '0;
        end else begin
            y_q     <= y_d;
            terms_q <= terms_d;
        end
    end

    assign Y     = y_q;
    assign TERMS = terms_q;

endmodule

// File: tb/tb_aoi_4.sv
module tb_aoi_4;
    import aoi_pkg::*;

`ifdef AOI_4_INPUT_SYNC_EN
    localparam int LAT = 1 + AOI_4_SYNC_STAGES;
`else
    localparam int LAT = 1;
`endif

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0, E = 1'b0;
    logic       F = 1'b0, G = 1'b0, H = 1'b0, I = 1'b0;
    logic       Y;
    logic [3:0] TERMS;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected {Y, TERMS} in flight; entry LAT-1 is what the outputs show.
    logic [4:0] pipe [LAT];

    always #5 CLK = ~CLK;

    aoi_4 dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .E     (E),
        .F     (F),
        .G     (G),
        .H     (H),
        .I     (I),
        .Y     (Y),
        .TERMS (TERMS)
    );

    function automatic logic [4:0] ref_fn(input logic [8:0] v);
        logic [3:0] t;
        t[0] = v[8] & v[7];
        t[1] = v[6] & v[5];
        t[2] = v[4] & v[3];
        t[3] = v[2] & v[1] & v[0];
        return {~(t[0] | t[1] | t[2] | t[3]), t};
    endfunction

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b required=%b", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [8:0] v);
        @(negedge CLK);
        {A, B, C, D, E, F, G, H, I} = v;
    endtask

    task automatic set_rst(input logic r);
        @(negedge CLK);
        RST_N = r;
    endtask

    // One rising edge: advance the expectation pipeline, then check outputs.
    task automatic tick();
        @(posedge CLK);
        if (!RST_N) begin
            for (int k = 0; k < LAT; k++) pipe[k] = 5'b1_0000;
        end else begin
            for (int k = LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = ref_fn({A, B, C, D, E, F, G, H, I});
        end
        #1;
        check("pipeline", {Y, TERMS}, pipe[LAT-1]);
        check("invariant", {4'b0, Y}, {4'b0, ~(|TERMS)});
    endtask

    task automatic apply_hold(input string tag, input logic [8:0] v, input logic [4:0] exp);
        set_in(v);
        repeat (LAT) tick();
        check(tag, {Y, TERMS}, exp);
    endtask

    initial begin
        // Reset with arbitrary (all-ones) inputs for two edges.
        set_in(9'h1FF);
        tick();
        check("reset_e1", {Y, TERMS}, 5'b1_0000);
        tick();
        check("reset_e2", {Y, TERMS}, 5'b1_0000);

        set_in(9'h000);
        set_rst(1'b1);
        repeat (LAT) tick();

        // Idle and a lone partial term keep Y high.
        apply_hold("all_zero",    9'b000_000_000, 5'b1_0000);
        apply_hold("i_only",      9'b000_000_001, 5'b1_0000);

        // Each full product term alone.
        apply_hold("term0_ab",    9'b110_000_000, 5'b0_0001);
        apply_hold("term1_cd",    9'b001_100_000, 5'b0_0010);
        apply_hold("term2_ef",    9'b000_011_000, 5'b0_0100);
        apply_hold("term3_ghi",   9'b000_000_111, 5'b0_1000);

        // All ones, and the 3-input term one short.
        apply_hold("all_ones",    9'b111_111_111, 5'b0_1111);
        apply_hold("gh_no_i",     9'b000_000_110, 5'b1_0000);

        // Exact latency: after a zero vector, AB=1 must not show before LAT edges.
        set_in(9'b000_000_000);
        repeat (LAT) tick();
        set_in(9'b110_000_000);
        for (int k = 1; k < LAT; k++) begin
            tick();
            check("lat_early", {Y, TERMS}, 5'b1_0000);
        end
        tick();
        check("lat_exact", {Y, TERMS}, 5'b0_0001);

        // Exhaustive sweep, new vector every cycle.
        for (int v = 0; v < 512; v++) begin
            set_in(v[8:0]);
            tick();
        end
        set_in(9'h000);
        repeat (LAT) tick();

        // Mid-stream reset with A=B=1 held.
        apply_hold("pre_rst_ab",  9'b110_000_000, 5'b0_0001);
        set_rst(1'b0);
        tick();
        check("midrst_edge", {Y, TERMS}, 5'b1_0000);
        set_rst(1'b1);
        for (int k = 1; k < LAT; k++) begin
            tick();
            check("midrst_flush", {Y, TERMS}, 5'b1_0000);
        end
        tick();
        check("midrst_recover", {Y, TERMS}, 5'b0_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
